req_priority_arbiter: RTL and testbench
=======================================

Name: req_priority_arbiter

Overview:
- Sequential 8-requester arbiter that shares one downstream resource.
- Uses the team's MSB-first priority-encode convention: bit 7 has highest priority, and En=1 disables the block.
- Registers a one-hot grant plus an encoded 3-bit owner ID.
- Holds the grant until the owner releases, drops its request, or a hold timer expires.

Parameters:
- MAX_HOLD, 16: max BUSY cycles per grant before forced revoke. 0 means no timeout.
- CNT_W, $clog2(MAX_HOLD+1) (min 1): hold counter width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Req  in  8  request vector; bit i = requester i
- Rel  in  1  release strobe from current owner, sampled only in BUSY
- En  in  1  active-high disable; 1 = no new grants, current grant revoked
- Gnt  out  8  registered one-hot grant; all-zero when no owner
- GntId  out  3  encoded index of owner; 0 when Valid=0
- Valid  out  1  1 while a grant is held
- Timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, immediate on rst=1):
  - state=IDLE; Gnt=0, GntId=0, Valid=0, Timeout=0.
  - hold counter=0; last-owner pointer=0.
- All outputs are registered. No combinational path from inputs to outputs.

- FSM states: IDLE, BUSY.

- IDLE:
  - If En=0 and |Req=1, arbitrate. Next cycle: Gnt=onehot(win), GntId=win, Valid=1, counter=0, state->BUSY.
  - Otherwise stay in IDLE with outputs 0.
  - Latency: Req visible at edge t gives Gnt at edge t+1.

- BUSY: counter increments each cycle, saturating at MAX_HOLD. Revoke conditions, in priority order:
  - 1. En=1: revoke. Timeout stays 0.
  - 2. Rel=1, or Req[GntId]=0: revoke.
  - 3. MAX_HOLD!=0 and counter==MAX_HOLD-1: revoke, and Timeout=1 for exactly the next cycle.
- Revoke means: next cycle Gnt=0, GntId=0, Valid=0, state->IDLE, last-owner pointer<=GntId.
- No back-to-back grants. At least one cycle with Valid=0 always separates owners, so a new grant appears 2 cycles after the release cycle at the earliest.
- Rel and Req changes from non-owners are ignored in BUSY. No preemption by a higher-priority request.
- Rel asserted in IDLE is ignored.
- Simultaneous Rel and timeout: treat as release, Timeout=0.
- En=1 in IDLE holds IDLE; Req is ignored and nothing is queued.
- Reset mid-grant: outputs clear asynchronously. No Timeout pulse.
- Invariant: Gnt is one-hot or zero, Gnt==(Valid ? 1<<GntId : 0), and Valid==|Gnt.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Search starts at index (last-owner pointer - 1) mod 8, descending with wrap.
  - First set Req bit found wins.
  - Reset pointer 0, so the first search starts at 7.
  - Every persistent requester is served within 8 grants.
- Undefined:
  - Fixed priority: highest set Req bit wins every arbitration.
  - The pointer register is still present but unused, and may be optimized away.

Test Plan:
- rst=1 with Req=8'hFF, En=0 -> Gnt=0, GntId=0, Valid=0, Timeout=0 throughout. After rst falls: Gnt=8'h80, GntId=7 one edge later.
- Req=8'b00100110, En=0 from IDLE -> next cycle Gnt=8'b00100000, GntId=5, Valid=1. Changing Req[1] while BUSY causes no change.
- Owner 5 pulses Rel, Req=8'b00000110 -> next cycle Gnt=0, Valid=0. Following cycle Gnt=8'b00000100, GntId=2.
- MAX_HOLD=4, owner 7 holds Req with no Rel -> Valid for exactly 4 cycles. Timeout=1 for one cycle coincident with Gnt=0. Rel and timeout in the same cycle -> Timeout stays 0.
- En=1 raised mid-BUSY -> Gnt=0 next cycle, Timeout=0. Req=8'hFF held with En=1 -> no grant. En=0 -> grant 7 one cycle later.
- Req=8'hFF constant, owner pulses Rel each grant:
  - Macro defined: GntId sequence 7,6,5,4,3,2,1,0,7.
  - Macro undefined: 7,7,7.

Source files
------------

// File: rtl/req_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : req_priority_arbiter
//  Description : Eight-requester arbiter for one shared downstream resource.
//                Bit 7 has the highest priority. En=1 disables the block and
//                revokes any current grant. The arbiter registers a one-hot
//                grant and a 3-bit owner ID, and holds the grant until the
//                owner releases, the owner drops its request, or the hold
//                timer expires.
//                Optional feature macro ARB_ROUND_ROBIN_EN: when defined, the
//                search starts just below the last owner and wraps downward.
//                When undefined, the arbiter uses fixed MSB-first priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_priority_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Req,
    input  logic       Rel,
    input  logic       En,
    output logic [7:0] Gnt,
    output logic [2:0] GntId,
    output logic       Valid,
    output logic       Timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic             c_timeout_en = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] c_hold_max   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_gnt;
    logic [7:0]       w_gnt_nxt;
    logic [2:0]       r_gntid;
    logic [2:0]       w_gntid_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    // Arbitration result
    logic [2:0]       w_start;
    logic [2:0]       w_win;
    logic             w_found;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;

    // Search begins one position below the last owner, so that owner goes last.
    assign w_start = r_ptr - 3'd1;

    // Last-owner pointer, updated whenever a grant is revoked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 3'd0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    // Fixed priority always searches from the top requester.
    assign w_start = 3'd7;
`endif

    // Descending search from w_start with wrap; the first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && Req[w_start - 3'(k)]) begin
                w_found = 1'b1;
                w_win   = w_start - 3'(k);
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gnt     <= 8'd0;
            r_gntid   <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gntid   <= w_gntid_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic: grant from IDLE, and prioritised revoke checks in BUSY.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_gntid_nxt   = r_gntid;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt     = r_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt   = 8'd0;
                w_gntid_nxt = 3'd0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
                if (!En && w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = 8'd1 << w_win;
                    w_gntid_nxt = w_win;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_BUSY: begin
                if (En || Rel || !Req[r_gntid] ||
                    (c_timeout_en && (r_cnt == c_hold_last))) begin
                    // A timeout is only reported when nothing else caused the revoke.
                    w_timeout_nxt = !En && !Rel && Req[r_gntid];
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = 8'd0;
                    w_gntid_nxt   = 3'd0;
                    w_valid_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt     = r_gntid;
`endif
                end else if (r_cnt != c_hold_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Gnt     = r_gnt;
    assign GntId   = r_gntid;
    assign Valid   = r_valid;
    assign Timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_priority_arbiter
//  Description : Scoreboard bench for req_priority_arbiter. The driver issues
//                one directed vector per cycle and queues the hand-computed
//                outputs expected after the next rising edge. The monitor pops
//                an entry each cycle and compares it, and it also checks the
//                grant/ID/valid invariant on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_priority_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Req = 8'hFF;
    logic       Rel = 1'b0;
    logic       En  = 1'b0;
    logic [7:0] Gnt;
    logic [2:0] GntId;
    logic       Valid;
    logic       Timeout;

    req_priority_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .Req     (Req),
        .Rel     (Rel),
        .En      (En),
        .Gnt     (Gnt),
        .GntId   (GntId),
        .Valid   (Valid),
        .Timeout (Timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   step_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    exp_t m_exp;
    int   m_step;
    logic [2:0] en_win;
    logic [2:0] rot_id;

    // Drive one vector at the falling edge and queue the outputs expected after the next rising edge.
    task automatic drive(input logic r, input logic [7:0] q, input logic rl, input logic e,
                         input logic ev, input logic [2:0] eid, input logic eto);
        exp_t x;
        @(negedge clk);
        rst = r;
        Req = q;
        Rel = rl;
        En  = e;
        step_no++;
        x.gnt   = ev ? (8'd1 << eid) : 8'd0;
        x.id    = eid;
        x.valid = ev;
        x.to    = eto;
        exp_q.push_back(x);
        step_q.push_back(step_no);
    endtask

    // Monitor: compare queued expectations and the output invariant just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_step = step_q.pop_front();
            checks++;
            if ({Gnt, GntId, Valid, Timeout} !== m_exp) begin
                failures++;
                $display("FAIL step%0d outputs: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
                         m_step, Gnt, GntId, Valid, Timeout, m_exp.gnt, m_exp.id, m_exp.valid, m_exp.to);
            end
        end
        checks++;
        if ((Gnt !== (Valid ? (8'd1 << GntId) : 8'd0)) || (Valid !== |Gnt)) begin
            failures++;
            $display("FAIL invariant: got gnt=%h id=%0d valid=%b", Gnt, GntId, Valid);
        end
    end

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        en_win = 3'd2;
`else
        en_win = 3'd7;
`endif
        // Reset held with all requests present: outputs stay clear.
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        drive(0, 8'hFF, 0, 0, 1, 3'd7, 0);
        drive(0, 8'hFF, 1, 0, 0, 3'd0, 0);
        // Mixed requests, then non-owner request changes while busy.
        drive(0, 8'b00100110, 0, 0, 1, 3'd5, 0);
        drive(0, 8'b00100100, 0, 0, 1, 3'd5, 0);
        drive(0, 8'b00100110, 0, 0, 1, 3'd5, 0);
        drive(0, 8'b00000110, 1, 0, 0, 3'd0, 0);
        drive(0, 8'b00000110, 0, 0, 1, 3'd2, 0);
        // Owner drops its request.
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0);
        // Hold timer expiry after four valid cycles.
        drive(0, 8'h80, 0, 0, 1, 3'd7, 0);
        drive(0, 8'h80, 0, 0, 1, 3'd7, 0);
        drive(0, 8'h80, 0, 0, 1, 3'd7, 0);
        drive(0, 8'h80, 0, 0, 1, 3'd7, 0);
        drive(0, 8'h80, 0, 0, 0, 3'd0, 1);
        // Rel in IDLE is ignored; the timeout pulse lasts one cycle.
        drive(0, 8'h00, 1, 0, 0, 3'd0, 0);
        // Release coinciding with the timeout cycle reports no timeout.
        drive(0, 8'h40, 0, 0, 1, 3'd6, 0);
        drive(0, 8'h40, 0, 0, 1, 3'd6, 0);
        drive(0, 8'h40, 0, 0, 1, 3'd6, 0);
        drive(0, 8'h40, 0, 0, 1, 3'd6, 0);
        drive(0, 8'h40, 1, 0, 0, 3'd0, 0);
        // Disable mid-grant, disable in IDLE, then re-enable.
        drive(0, 8'h08, 0, 0, 1, 3'd3, 0);
        drive(0, 8'h08, 0, 1, 0, 3'd0, 0);
        drive(0, 8'hFF, 0, 1, 0, 3'd0, 0);
        drive(0, 8'hFF, 0, 1, 0, 3'd0, 0);
        drive(0, 8'hFF, 0, 0, 1, en_win, 0);
        drive(0, 8'hFF, 1, 0, 0, 3'd0, 0);
        // Rotation from a fresh reset with every requester persistent.
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        for (int g = 0; g < 9; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            rot_id = 3'(7 - g);
`else
            rot_id = 3'd7;
`endif
            drive(0, 8'hFF, 0, 0, 1, rot_id, 0);
            if (g < 8) drive(0, 8'hFF, 1, 0, 0, 3'd0, 0);
        end
        // Asynchronous reset mid-grant clears outputs immediately with no timeout.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({Gnt, GntId, Valid, Timeout} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got gnt=%h id=%0d valid=%b timeout=%b, expected all zero",
                     Gnt, GntId, Valid, Timeout);
        end
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        drive(1, 8'hFF, 0, 0, 0, 3'd0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
